register_file: RTL and testbench



---
 rtl/register_file.sv | 57 +++++
 tb/tb_register_file.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// General-purpose register file for the LEGv8 datapath: two combinational
// read ports (Rn/Rm), one clocked write port (Rd), and a hard-wired zero register XZR.
module register_file #(
   parameter int BITSIZE = 64,
   parameter int REGSIZE = 32,
   localparam int SELW = $clog2(REGSIZE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SELW-1:0]    ReadSelect1,
   input  logic [SELW-1:0]    ReadSelect2,
   input  logic [SELW-1:0]    WriteSelect,
   input  logic [BITSIZE-1:0] WriteData,
   input  logic               WriteEnable,
   output logic [BITSIZE-1:0] ReadData1,
   output logic [BITSIZE-1:0] ReadData2
);

   localparam int ZERO_INDEX = REGSIZE - 1;

   logic [BITSIZE-1:0] regs [REGSIZE];
   logic               write_ok;
   logic               read1_ok;
   logic               read2_ok;

   // Indices at or above XZR are never stored, so the zero register cannot be overwritten
   // and out-of-range selects read zero.
   always_comb begin
      write_ok = WriteEnable && (int'(WriteSelect) < ZERO_INDEX);
      read1_ok = int'(ReadSelect1) < ZERO_INDEX;
      read2_ok = int'(ReadSelect2) < ZERO_INDEX;
   end

   // Reset clears the whole array asynchronously and blocks writes while held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REGSIZE; i++) begin
            regs[i] <= '0;
         end
      end else if (write_ok) begin
         regs[WriteSelect] <= WriteData;
      end
   end

   // Reads have no bypass: they track stored contents only.
   always_comb begin
      ReadData1 = '0;
      ReadData2 = '0;
      if (read1_ok) begin
         ReadData1 = regs[ReadSelect1];
      end
      if (read2_ok) begin
         ReadData2 = regs[ReadSelect2];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: expected read pairs are queued as stimulus
// is driven and popped when the read ports are sampled.
module tb_register_file;

   localparam int BITSIZE = 64;
   localparam int REGSIZE = 32;
   localparam int SELW = 5;

   typedef struct {
      string              tag;
      logic [BITSIZE-1:0] exp1;
      logic [BITSIZE-1:0] exp2;
   } expect_t;

   logic               clk;
   logic               rst;
   logic [SELW-1:0]    ReadSelect1;
   logic [SELW-1:0]    ReadSelect2;
   logic [SELW-1:0]    WriteSelect;
   logic [BITSIZE-1:0] WriteData;
   logic               WriteEnable;
   logic [BITSIZE-1:0] ReadData1;
   logic [BITSIZE-1:0] ReadData2;

   expect_t            scoreboard[$];
   logic [BITSIZE-1:0] model [REGSIZE];
   int                 assertCount;
   int                 failCount;

   register_file #(.BITSIZE(BITSIZE), .REGSIZE(REGSIZE)) dut (
      .clk(clk),
      .rst(rst),
      .ReadSelect1(ReadSelect1),
      .ReadSelect2(ReadSelect2),
      .WriteSelect(WriteSelect),
      .WriteData(WriteData),
      .WriteEnable(WriteEnable),
      .ReadData1(ReadData1),
      .ReadData2(ReadData2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [BITSIZE-1:0] observed,
                              input logic [BITSIZE-1:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Queue the read-port values the design must show at the next sample.
   task automatic expectReads(input string tag, input logic [BITSIZE-1:0] e1,
                              input logic [BITSIZE-1:0] e2);
      expect_t item;
      item.tag  = tag;
      item.exp1 = e1;
      item.exp2 = e2;
      scoreboard.push_back(item);
   endtask

   // Pop the oldest expectation and compare both read ports against it.
   task automatic compareReads();
      expect_t item;
      if (scoreboard.size() == 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL scoreboard_empty: observed no entry expected one entry");
      end else begin
         item = scoreboard.pop_front();
         checkOutput({item.tag, "_rd1"}, ReadData1, item.exp1);
         checkOutput({item.tag, "_rd2"}, ReadData2, item.exp2);
      end
   endtask

   task automatic applyStimulus(input logic [SELW-1:0] sel1, input logic [SELW-1:0] sel2);
      ReadSelect1 = sel1;
      ReadSelect2 = sel2;
   endtask

   // One write cycle driven from the falling edge; the model mirrors the architectural rule.
   task automatic writeReg(input logic [SELW-1:0] sel, input logic [BITSIZE-1:0] data);
      @(negedge clk);
      WriteEnable = 1'b1;
      WriteSelect = sel;
      WriteData   = data;
      @(posedge clk);
      if (int'(sel) != REGSIZE - 1) model[sel] = data;
      @(negedge clk);
      WriteEnable = 1'b0;
   endtask

   initial begin
      logic [BITSIZE-1:0] value;
      assertCount = 0;
      failCount   = 0;
      rst         = 1'b0;
      WriteEnable = 1'b0;
      WriteSelect = '0;
      WriteData   = '0;
      applyStimulus(5'd0, 5'd0);

      // Asynchronous reset pulse, raised mid-cycle away from any edge.
      @(negedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < REGSIZE; i++) model[i] = '0;
      #1;
      expectReads("reset_async", '0, '0);
      compareReads();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < REGSIZE; i++) begin
         applyStimulus(SELW'(i), SELW'(REGSIZE - 1 - i));
         #1;
         expectReads($sformatf("reset_sweep_%0d", i), '0, '0);
         compareReads();
      end

      // Write then read.
      writeReg(5'd4, 64'hF);
      applyStimulus(5'd4, 5'd3);
      #1;
      expectReads("write_read", 64'hF, 64'h0);
      compareReads();

      // Write disabled for several edges.
      @(negedge clk);
      WriteEnable = 1'b0;
      WriteSelect = 5'd2;
      WriteData   = 64'hDEAD;
      repeat (3) @(negedge clk);
      applyStimulus(5'd2, 5'd2);
      #1;
      expectReads("write_disabled", '0, '0);
      compareReads();

      // Reset mid-operation with a pending write that must be lost.
      @(negedge clk);
      applyStimulus(5'd4, 5'd4);
      #1;
      expectReads("pre_reset", 64'hF, 64'hF);
      compareReads();
      #1;
      rst         = 1'b1;
      WriteEnable = 1'b1;
      WriteSelect = 5'd4;
      WriteData   = 64'h1234;
      for (int i = 0; i < REGSIZE; i++) model[i] = '0;
      #1;
      expectReads("reset_immediate", '0, '0);
      compareReads();
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         expectReads($sformatf("reset_held_%0d", k), '0, '0);
         compareReads();
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      expectReads("reset_released", '0, '0);
      compareReads();
      @(posedge clk);
      model[4] = 64'h1234;
      #1;
      expectReads("first_write_after_reset", model[4], model[4]);
      compareReads();
      @(negedge clk);
      WriteEnable = 1'b0;

      // Same index on both ports, old value before the edge and new value after it.
      for (int k = 0; k < 2; k++) begin
         value = (k == 0) ? 64'hA5A5_0000_FFFF_0001 : 64'h0123_4567_89AB_CDEF;
         @(negedge clk);
         applyStimulus(5'd5, 5'd5);
         WriteEnable = 1'b1;
         WriteSelect = 5'd5;
         WriteData   = value;
         #1;
         expectReads($sformatf("dual_pre_%0d", k), model[5], model[5]);
         compareReads();
         @(posedge clk);
         model[5] = value;
         #1;
         expectReads($sformatf("dual_post_%0d", k), value, value);
         compareReads();
         @(negedge clk);
         WriteEnable = 1'b0;
      end

      // Zero register discards writes.
      writeReg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(5'd31, 5'd31);
      #1;
      expectReads("xzr_read", '0, '0);
      compareReads();

      // Distinct value in every writable register, then read back for aliasing.
      for (int i = 0; i < REGSIZE - 1; i++) begin
         writeReg(SELW'(i), {32'hC0DE_0000 | 32'(i), 32'(i * 7 + 3)});
      end
      for (int i = 0; i < REGSIZE; i++) begin
         applyStimulus(SELW'(i), SELW'(REGSIZE - 1 - i));
         #1;
         expectReads($sformatf("sweep_%0d", i), model[i], model[REGSIZE - 1 - i]);
         compareReads();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
